// File: rtl/alu_sequencer.sv
// Control FSM for the lab ALU: collects opcode/A/B from debounced button strobes,
// fires a one-cycle ALU start, waits for done under a timeout and holds the result.
module alu_sequencer #(
    parameter int                          WIDTH      = 4,
    parameter int                          OP_WIDTH   = 3,
    parameter logic [(2**OP_WIDTH)-1:0]    UNARY_MASK = 8'b1100_0000,
    parameter int                          TIMEOUT    = 16
) (
    input  logic                  in_clk,
    input  logic                  reset_n,
    input  logic                  inc_pulse,
    input  logic                  save_pulse,
    input  logic                  clear_pulse,
    input  logic [2*WIDTH-1:0]    alu_result,
    input  logic                  alu_done,
    output logic [WIDTH-1:0]      A,
    output logic [WIDTH-1:0]      B,
    output logic [OP_WIDTH-1:0]   opCode,
    output logic                  alu_start,
    output logic [2*WIDTH-1:0]    result,
    output logic                  result_valid,
    output logic [2:0]            state,
    output logic                  timeout_err
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_WAIT = 3'd4,
        S_SHOW = 3'd5,
        S_ERR  = 3'd6,
        S_BAD  = 3'd7
    } state_t;

    state_t                cur, nxt;
    logic [CW-1:0]         cnt, next_cnt;
    logic [WIDTH-1:0]      next_a, next_b;
    logic [OP_WIDTH-1:0]   next_op;
    logic [2*WIDTH-1:0]    next_result;
    logic                  next_valid, next_err;

    always_comb begin
        nxt         = cur;
        next_a      = A;
        next_b      = B;
        next_op     = opCode;
        next_result = result;
        next_valid  = result_valid;
        next_err    = timeout_err;
        next_cnt    = cnt;
        if (clear_pulse) begin
            // Abort from anywhere; an in-flight ALU op is simply forgotten.
            nxt         = S_OP;
            next_a      = '0;
            next_b      = '0;
            next_op     = '0;
            next_result = '0;
            next_valid  = 1'b0;
            next_err    = 1'b0;
            next_cnt    = '0;
        end else begin
            case (cur)
                S_OP: begin
                    if (save_pulse)     nxt = S_A;
                    else if (inc_pulse) next_op = opCode + OP_WIDTH'(1);
                end
                S_A: begin
                    if (save_pulse) begin
                        if (UNARY_MASK[opCode]) begin
                            next_b = '0;
                            nxt    = S_EXEC;
                        end else begin
                            nxt = S_B;
                        end
                    end else if (inc_pulse) begin
                        next_a = A + WIDTH'(1);
                    end
                end
                S_B: begin
                    if (save_pulse)     nxt = S_EXEC;
                    else if (inc_pulse) next_b = B + WIDTH'(1);
                end
                S_EXEC: begin
                    next_cnt = '0;
                    nxt      = S_WAIT;
                end
                S_WAIT: begin
                    // done takes precedence over an expiring count in the same cycle
                    if (alu_done) begin
                        next_result = alu_result;
                        next_valid  = 1'b1;
                        nxt         = S_SHOW;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        next_err = 1'b1;
                        nxt      = S_ERR;
                    end else begin
                        next_cnt = cnt + CW'(1);
                    end
                end
                S_SHOW: begin
                    if (save_pulse) begin
                        next_valid = 1'b0;
                        nxt        = S_OP;
                    end
                end
                S_ERR: begin
                    next_valid = 1'b0;
                    if (save_pulse) begin
                        next_err = 1'b0;
                        nxt      = S_OP;
                    end
                end
                default: nxt = S_OP;
            endcase
        end
    end

    always_ff @(posedge in_clk) begin
        if (!reset_n) begin
            cur          <= S_OP;
            A            <= '0;
            B            <= '0;
            opCode       <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            alu_start    <= 1'b0;
            cnt          <= '0;
        end else begin
            cur          <= nxt;
            A            <= next_a;
            B            <= next_b;
            opCode       <= next_op;
            result       <= next_result;
            result_valid <= next_valid;
            timeout_err  <= next_err;
            cnt          <= next_cnt;
            // Registered start: high exactly while the state register reads S_EXEC.
            alu_start    <= (nxt == S_EXEC);
        end
    end

    assign state = cur;

endmodule
